muldiv_unit: RTL and testbench

Iterative RV32M multiply/divide unit in the execute stage of the pipelined core. It accepts an M-extension operation from execute and computes it over multiple cycles. It raises a stall request toward the hazard logic, so fetch, decode and execute hold while the operation runs, then returns a one-cycle-valid result that the pipeline carries into memory. It is the stall *source* the hazard logic consumes, and it obeys the execute-stage flush the hazard logic produces.

---
 rtl/muldiv_pkg.sv | 10 +
 rtl/muldiv_if.sv | 12 +
 rtl/seq_divider.sv | 33 +++
 rtl/muldiv_unit.sv | 89 ++++++++
 tb/tb_muldiv_unit.sv | 296 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/muldiv_pkg.sv
// muldiv_pkg: shared types and constants for the RV32M multiply/divide unit
package muldiv_pkg;
  localparam int XLEN = 32;
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  localparam logic [2:0] F3_MUL = 3'b000, F3_MULH = 3'b001, F3_MULHSU = 3'b010, F3_MULHU = 3'b011;
  localparam logic [2:0] F3_DIV = 3'b100, F3_DIVU = 3'b101, F3_REM = 3'b110, F3_REMU = 3'b111;
  localparam logic [XLEN-1:0] DIV0_QUO = 32'hFFFF_FFFF;
  localparam logic [XLEN-1:0] INT_MIN = 32'h8000_0000;
  localparam logic [XLEN-1:0] NEG_ONE = 32'hFFFF_FFFF;
endpackage

// File: rtl/muldiv_if.sv
// muldiv_if: execute-stage handshake between the pipeline and the multiply/divide unit
interface muldiv_if #(parameter int WIDTH = 32);
  logic StartE;
  logic [2:0] Funct3E;
  logic [WIDTH-1:0] SrcAE, SrcBE;
  logic FlushE;
  logic StallReq;
  logic ResultValid;
  logic [WIDTH-1:0] MulDivResult;
  modport master(output StartE, Funct3E, SrcAE, SrcBE, FlushE, input StallReq, ResultValid, MulDivResult);
  modport slave(input StartE, Funct3E, SrcAE, SrcBE, FlushE, output StallReq, ResultValid, MulDivResult);
endinterface

// File: rtl/seq_divider.sv
// seq_divider: restoring divider on magnitudes, one quotient bit per step
module seq_divider import muldiv_pkg::*; #(parameter int WIDTH = XLEN) (
  input  logic clk,
  input  logic rst_n,
  input  logic load,
  input  logic step,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] quo_nxt,
  output logic [WIDTH-1:0] rem_nxt
);
  logic [WIDTH-1:0] quo, rem, dvs;
  logic [WIDTH:0] shifted, diff;
  always_comb begin
    shifted = {rem, quo[WIDTH-1]};
    diff = shifted - {1'b0, dvs};
    rem_nxt = diff[WIDTH] ? shifted[WIDTH-1:0] : diff[WIDTH-1:0];
    quo_nxt = {quo[WIDTH-2:0], ~diff[WIDTH]};
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      quo <= '0;
      rem <= '0;
      dvs <= '0;
    end else if (load) begin
      quo <= dividend;
      rem <= '0;
      dvs <= divisor;
    end else if (step) begin
      quo <= quo_nxt;
      rem <= rem_nxt;
    end
endmodule

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative RV32M multiply/divide with pipeline stall request and flush abort
// MULDIV_FAST_MUL_EN selects a single-cycle multiplier for MUL/MULH/MULHSU/MULHU.
module muldiv_unit import muldiv_pkg::*; #(parameter int WIDTH = XLEN) (
  input logic clk,
  input logic rst_n,
  muldiv_if.slave bus
);
  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] CNT_MAX = CW'(WIDTH - 1);
  state_t state, state_n;
  logic [CW-1:0] cnt;
  logic [2:0] f3, f3_in;
  logic neg, rv, start, sgn_a, sgn_b, sa, sb, div0, ovf, special, direct;
  logic [WIDTH-1:0] a, b, mag_a, mag_b, mcand, res, spec_res, direct_res, iter_res, dfin, quo_nxt, rem_nxt;
  logic [WIDTH:0] psum;
  logic [2*WIDTH-1:0] prod, prod_n, pfin;
`ifdef MULDIV_FAST_MUL_EN
  logic [2*WIDTH-1:0] fast_p;
`endif
  assign a = bus.SrcAE;
  assign b = bus.SrcBE;
  assign f3_in = bus.Funct3E;
  always_comb begin
    start = bus.StartE & ~bus.FlushE;
    sgn_a = f3_in[2] ? ~f3_in[0] : f3_in[1:0] != 2'b11;
    sgn_b = f3_in[2] ? ~f3_in[0] : ~f3_in[1];
    sa = a[WIDTH-1] & sgn_a;
    sb = b[WIDTH-1] & sgn_b;
    mag_a = sa ? -a : a;
    mag_b = sb ? -b : b;
    div0 = b == '0;
    ovf = ~f3_in[0] & (a == INT_MIN) & (b == NEG_ONE);
    special = f3_in[2] & (div0 | ovf);
    spec_res = f3_in[1] ? (div0 ? a : '0) : (div0 ? DIV0_QUO : INT_MIN);
    // one shift-add step: add multiplicand to the high half, then shift the whole product right
    psum = {1'b0, prod[2*WIDTH-1:WIDTH]} + (prod[0] ? {1'b0, mcand} : '0);
    prod_n = {psum, prod[WIDTH-1:1]};
    pfin = neg ? -prod_n : prod_n;
    dfin = f3[1] ? rem_nxt : quo_nxt;
    iter_res = f3[2] ? (neg ? -dfin : dfin) : (f3[1:0] == 2'b00 ? pfin[WIDTH-1:0] : pfin[2*WIDTH-1:WIDTH]);
`ifdef MULDIV_FAST_MUL_EN
    fast_p = $signed({{WIDTH{sa}}, a}) * $signed({{WIDTH{sb}}, b});
    direct = special | ~f3_in[2];
    direct_res = f3_in[2] ? spec_res : (f3_in[1:0] == 2'b00 ? fast_p[WIDTH-1:0] : fast_p[2*WIDTH-1:WIDTH]);
`else
    direct = special;
    direct_res = spec_res;
`endif
    state_n = bus.FlushE ? IDLE :
              state == IDLE ? (start ? (direct ? DONE : BUSY) : IDLE) :
              state == BUSY ? (cnt == '0 ? DONE : BUSY) : IDLE;
  end
  assign bus.StallReq = rst_n & ~bus.FlushE & (state == IDLE ? bus.StartE : state == BUSY);
  assign bus.ResultValid = rv;
  assign bus.MulDivResult = res;
  seq_divider #(.WIDTH(WIDTH)) u_div (
    .clk(clk), .rst_n(rst_n),
    .load(state == IDLE && start), .step(state == BUSY),
    .dividend(mag_a), .divisor(mag_b),
    .quo_nxt(quo_nxt), .rem_nxt(rem_nxt)
  );
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      cnt <= '0;
      f3 <= '0;
      neg <= 1'b0;
      mcand <= '0;
      prod <= '0;
      rv <= 1'b0;
      res <= '0;
    end else begin
      state <= state_n;
      rv <= state_n == DONE;
      if (state == IDLE && start) begin
        f3 <= f3_in;
        neg <= (f3_in[2] & f3_in[1]) ? sa : sa ^ sb;
        mcand <= mag_a;
        prod <= {{WIDTH{1'b0}}, mag_b};
        cnt <= CNT_MAX;
        if (direct) res <= direct_res;
      end
      if (state == BUSY) begin
        prod <= prod_n;
        cnt <= cnt - 1'b1;
        if (state_n == DONE) res <= iter_res;
      end
    end
endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: scoreboard bench for muldiv_unit covering latency, results, flush and async reset
module tb_muldiv_unit;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  muldiv_if bus();
  muldiv_unit dut(.clk(clk), .rst_n(rst_n), .bus(bus));
  logic [31:0] sb_q[$];
  int n_cmp = 0;
  int n_err = 0;

  function automatic logic [31:0] model(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    logic signed [63:0] xs, ys;
    logic [63:0] xu, yu, p;
    logic signed [31:0] as_, bs_, q;
    logic ovf;
    xs = {{32{a[31]}}, a};
    ys = {{32{b[31]}}, b};
    xu = {32'b0, a};
    yu = {32'b0, b};
    as_ = a;
    bs_ = b;
    ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    p = '0;
    q = '0;
    case (f)
      3'd0: begin p = xu * yu; return p[31:0]; end
      3'd1: begin p = xs * ys; return p[63:32]; end
      3'd2: begin p = xs * $signed(yu); return p[63:32]; end
      3'd3: begin p = xu * yu; return p[63:32]; end
      3'd4: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (ovf) return 32'h8000_0000;
        q = as_ / bs_;
        return q;
      end
      3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'd6: begin
        if (b == 0) return a;
        if (ovf) return 32'h0;
        q = as_ % bs_;
        return q;
      end
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  function automatic int lat(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    if (f[2] && (b == 0 || (!f[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF))) return 2;
`ifdef MULDIV_FAST_MUL_EN
    if (!f[2]) return 2;
`endif
    return 34;
  endfunction

  task automatic issue(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b, input logic [31:0] e);
    @(negedge clk);
    bus.StartE = 1'b1;
    bus.FlushE = 1'b0;
    bus.Funct3E = f;
    bus.SrcAE = a;
    bus.SrcBE = b;
    sb_q.push_back(e);
  endtask

  task automatic collect(output logic got, output logic [31:0] r, output int cyc, output int st);
    got = 1'b0;
    r = '0;
    cyc = 1;
    st = 0;
    while (!got && cyc <= 60) begin
      #1;
      st += int'(bus.StallReq);
      if (bus.ResultValid) begin
        got = 1'b1;
        r = bus.MulDivResult;
      end else begin
        @(negedge clk);
        cyc++;
      end
    end
  endtask

  task automatic idle();
    @(negedge clk);
    bus.StartE = 1'b0;
  endtask

  task automatic test_reset();
    #12;
    n_cmp += 3;
    if (bus.StallReq !== 1'b0) begin n_err++; $display("FAIL reset StallReq: got %b expected 0", bus.StallReq); end
    if (bus.ResultValid !== 1'b0) begin n_err++; $display("FAIL reset ResultValid: got %b expected 0", bus.ResultValid); end
    if (bus.MulDivResult !== 32'h0) begin n_err++; $display("FAIL reset MulDivResult: got %h expected 0", bus.MulDivResult); end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_mul();
    logic [2:0] fs[4];
    logic [31:0] av[4], bv[4], ev[4];
    logic got;
    logic [31:0] r, e;
    int cyc, st, l;
    fs = '{3'd0, 3'd3, 3'd1, 3'd2};
    av = '{32'd7, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
    bv = '{32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
    ev = '{32'hFFFF_FFEB, 32'hFFFF_FFFE, 32'h0000_0000, 32'hFFFF_FFFF};
    for (int i = 0; i < 4; i++) begin
      issue(fs[i], av[i], bv[i], ev[i]);
      collect(got, r, cyc, st);
      e = sb_q.pop_front();
      l = lat(fs[i], av[i], bv[i]);
      n_cmp++;
      if (!got) begin n_err++; $display("FAIL mul[%0d] timeout: no ResultValid, expected at cycle %0d", i, l); end
      else begin
        n_cmp += 3;
        if (r !== e) begin n_err++; $display("FAIL mul[%0d] result: got %h expected %h", i, r, e); end
        if (cyc !== l) begin n_err++; $display("FAIL mul[%0d] valid cycle: got %0d expected %0d", i, cyc, l); end
        if (st !== l - 1) begin n_err++; $display("FAIL mul[%0d] stall cycles: got %0d expected %0d", i, st, l - 1); end
      end
      idle();
    end
  endtask

  task automatic test_div();
    logic [2:0] fs[4];
    logic [31:0] av[4], bv[4], ev[4];
    logic got;
    logic [31:0] r, e;
    int cyc, st, l;
    fs = '{3'd4, 3'd6, 3'd5, 3'd7};
    av = '{32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'd100, 32'd100};
    bv = '{32'd2, 32'd2, 32'd7, 32'd7};
    ev = '{32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'd14, 32'd2};
    for (int i = 0; i < 4; i++) begin
      issue(fs[i], av[i], bv[i], ev[i]);
      collect(got, r, cyc, st);
      e = sb_q.pop_front();
      l = lat(fs[i], av[i], bv[i]);
      n_cmp++;
      if (!got) begin n_err++; $display("FAIL div[%0d] timeout: no ResultValid, expected at cycle %0d", i, l); end
      else begin
        n_cmp += 3;
        if (r !== e) begin n_err++; $display("FAIL div[%0d] result: got %h expected %h", i, r, e); end
        if (cyc !== l) begin n_err++; $display("FAIL div[%0d] valid cycle: got %0d expected %0d", i, cyc, l); end
        if (st !== l - 1) begin n_err++; $display("FAIL div[%0d] stall cycles: got %0d expected %0d", i, st, l - 1); end
      end
      idle();
    end
  endtask

  task automatic test_special();
    logic [2:0] fs[6];
    logic [31:0] av[6], bv[6], ev[6];
    logic got;
    logic [31:0] r, e;
    int cyc, st;
    fs = '{3'd4, 3'd6, 3'd4, 3'd6, 3'd5, 3'd7};
    av = '{32'h1234_5678, 32'h1234_5678, 32'h8000_0000, 32'h8000_0000, 32'h8765_4321, 32'h8765_4321};
    bv = '{32'h0, 32'h0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0, 32'h0};
    ev = '{32'hFFFF_FFFF, 32'h1234_5678, 32'h8000_0000, 32'h0, 32'hFFFF_FFFF, 32'h8765_4321};
    for (int i = 0; i < 6; i++) begin
      issue(fs[i], av[i], bv[i], ev[i]);
      collect(got, r, cyc, st);
      e = sb_q.pop_front();
      n_cmp++;
      if (!got) begin n_err++; $display("FAIL special[%0d] timeout: no ResultValid, expected at cycle 2", i); end
      else begin
        n_cmp += 3;
        if (r !== e) begin n_err++; $display("FAIL special[%0d] result: got %h expected %h", i, r, e); end
        if (cyc !== 2) begin n_err++; $display("FAIL special[%0d] valid cycle: got %0d expected 2", i, cyc); end
        if (st !== 1) begin n_err++; $display("FAIL special[%0d] stall cycles: got %0d expected 1", i, st); end
      end
      idle();
    end
  endtask

  task automatic test_back_to_back();
    logic [2:0] f;
    logic [31:0] a, b, r, e, last;
    logic got;
    int cyc, st, l;
    last = '0;
    for (int i = 0; i < 14; i++) begin
      f = 3'($urandom_range(0, 7));
      a = (i % 3 == 1) ? 32'($urandom_range(0, 1000)) : $urandom;
      b = (i % 5 == 3) ? 32'h0 : (i % 3 == 2) ? 32'($urandom_range(1, 50)) : $urandom;
      issue(f, a, b, model(f, a, b));
      collect(got, r, cyc, st);
      e = sb_q.pop_front();
      l = lat(f, a, b);
      last = e;
      n_cmp++;
      if (!got) begin n_err++; $display("FAIL b2b[%0d] timeout: f3=%0d a=%h b=%h", i, f, a, b); end
      else begin
        n_cmp += 2;
        if (r !== e) begin n_err++; $display("FAIL b2b[%0d] result f3=%0d a=%h b=%h: got %h expected %h", i, f, a, b, r, e); end
        if (cyc !== l) begin n_err++; $display("FAIL b2b[%0d] valid cycle: got %0d expected %0d", i, cyc, l); end
      end
    end
    idle();
    repeat (3) @(negedge clk);
    #1;
    n_cmp += 2;
    if (bus.ResultValid !== 1'b0) begin n_err++; $display("FAIL hold ResultValid: got %b expected 0", bus.ResultValid); end
    if (bus.MulDivResult !== last) begin n_err++; $display("FAIL hold MulDivResult: got %h expected %h", bus.MulDivResult, last); end
  endtask

  task automatic test_flush();
    logic rv_seen, st_seen, got;
    logic [31:0] r, e;
    int cyc, st;
    @(negedge clk);
    bus.StartE = 1'b1;
    bus.Funct3E = 3'd5;
    bus.SrcAE = 32'd1000;
    bus.SrcBE = 32'd7;
    repeat (10) @(negedge clk);
    #1;
    n_cmp++;
    if (bus.StallReq !== 1'b1) begin n_err++; $display("FAIL flush busy StallReq: got %b expected 1", bus.StallReq); end
    bus.FlushE = 1'b1;
    #1;
    n_cmp++;
    if (bus.StallReq !== 1'b0) begin n_err++; $display("FAIL flush cycle StallReq: got %b expected 0", bus.StallReq); end
    @(negedge clk);
    bus.FlushE = 1'b0;
    bus.StartE = 1'b0;
    rv_seen = 1'b0;
    st_seen = 1'b0;
    repeat (40) begin
      #1;
      rv_seen |= bus.ResultValid;
      st_seen |= bus.StallReq;
      @(negedge clk);
    end
    n_cmp += 2;
    if (rv_seen !== 1'b0) begin n_err++; $display("FAIL flush ResultValid seen: got %b expected 0", rv_seen); end
    if (st_seen !== 1'b0) begin n_err++; $display("FAIL flush StallReq seen: got %b expected 0", st_seen); end
    issue(3'd5, 32'd100, 32'd7, 32'd14);
    collect(got, r, cyc, st);
    e = sb_q.pop_front();
    n_cmp++;
    if (!got || r !== e) begin n_err++; $display("FAIL post-flush DIVU: got %h (valid=%b) expected %h", r, got, e); end
    idle();
  endtask

  task automatic test_async_reset();
    logic got;
    logic [31:0] r, e;
    int cyc, st;
    @(negedge clk);
    bus.StartE = 1'b1;
    bus.Funct3E = 3'd0;
    bus.SrcAE = 32'd5;
    bus.SrcBE = 32'd6;
    repeat (5) @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    n_cmp += 3;
    if (bus.StallReq !== 1'b0) begin n_err++; $display("FAIL async rst StallReq: got %b expected 0", bus.StallReq); end
    if (bus.ResultValid !== 1'b0) begin n_err++; $display("FAIL async rst ResultValid: got %b expected 0", bus.ResultValid); end
    if (bus.MulDivResult !== 32'h0) begin n_err++; $display("FAIL async rst MulDivResult: got %h expected 0", bus.MulDivResult); end
    bus.StartE = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    issue(3'd5, 32'd9, 32'd3, 32'd3);
    collect(got, r, cyc, st);
    e = sb_q.pop_front();
    n_cmp += 2;
    if (!got || r !== e) begin n_err++; $display("FAIL post-reset DIVU: got %h (valid=%b) expected %h", r, got, e); end
    if (cyc !== 34) begin n_err++; $display("FAIL post-reset DIVU cycle: got %0d expected 34", cyc); end
    idle();
  endtask

  initial begin
    bus.StartE = 1'b0;
    bus.FlushE = 1'b0;
    bus.Funct3E = 3'd0;
    bus.SrcAE = '0;
    bus.SrcBE = '0;
    test_reset();
    test_mul();
    test_div();
    test_special();
    test_back_to_back();
    test_flush();
    test_async_reset();
    n_cmp++;
    if (sb_q.size() !== 0) begin n_err++; $display("FAIL scoreboard leftover: got %0d entries expected 0", sb_q.size()); end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
